// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: owner states and port identifiers.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_hold;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_lock;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_hold, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_hold, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with clear and load-one; clear has highest priority.
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             load1,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load1) begin
      r_cnt <= WIDTH'(1);
    end else if (inc && (r_cnt < WIDTH'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority CPU/DMA arbiter for a single-port RAM with DMA burst lock
// and a starvation override guaranteeing DMA progress.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned AW           = 12,
  parameter int unsigned DW           = 16,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  owner_e        r_owner;
  logic [AW-1:0] r_mem_addr;
  logic          r_rd_pend;
  logic          r_rd_port;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;

  logic [7:0]    w_burst_cnt;
  logic [7:0]    w_starve_cnt;
  logic          w_force_dma;
  logic          w_keep_dma;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_mem_we;
  logic          w_rd_issue;
  logic          w_rd_port;
  logic          w_cpu_rvalid;
  logic          w_dma_rvalid;

  // Grants are forced low while reset is asserted so nothing reaches the RAM.
  always_comb begin
    w_force_dma = bus.dma_req && (w_starve_cnt >= 8'(STARVE_LIMIT));
    w_keep_dma  = (r_owner == DMA) && bus.dma_lock && bus.dma_req &&
                  ((w_burst_cnt < 8'(MAX_BURST)) || !bus.cpu_req);
    w_dma_gnt   = rst && (w_force_dma || w_keep_dma ||
                          (bus.dma_req && !bus.cpu_req));
    w_cpu_gnt   = rst && bus.cpu_req && !w_force_dma && !w_keep_dma;
  end

  always_comb begin
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_port   = PORT_CPU;
    if (w_cpu_gnt) begin
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
      w_mem_we    = bus.cpu_we;
      w_rd_issue  = !bus.cpu_we;
      w_rd_port   = PORT_CPU;
    end else if (w_dma_gnt) begin
      w_mem_addr  = bus.dma_addr;
      w_mem_wdata = bus.dma_wdata;
      w_mem_we    = bus.dma_we;
      w_rd_issue  = !bus.dma_we;
      w_rd_port   = PORT_DMA;
    end
  end

  assign w_cpu_rvalid = r_rd_pend && (r_rd_port == PORT_CPU);
  assign w_dma_rvalid = r_rd_pend && (r_rd_port == PORT_DMA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= IDLE;
      r_mem_addr  <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_port   <= PORT_CPU;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_dma_gnt) begin
        r_owner <= DMA;
      end else if (w_cpu_gnt) begin
        r_owner <= CPU;
      end else begin
        r_owner <= IDLE;
      end
      if (w_cpu_gnt || w_dma_gnt) begin
        r_mem_addr <= w_mem_addr;
      end
      r_rd_pend <= w_rd_issue;
      r_rd_port <= w_rd_port;
      if (w_cpu_rvalid) begin
        r_cpu_rdata <= bus.mem_rdata;
      end
      if (w_dma_rvalid) begin
        r_dma_rdata <= bus.mem_rdata;
      end
    end
  end

  sat_counter #(.WIDTH(8), .LIMIT(255)) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_dma_gnt && (r_owner == DMA)),
    .clr   (!w_dma_gnt),
    .load1 (w_dma_gnt && (r_owner != DMA)),
    .cnt   (w_burst_cnt)
  );

  sat_counter #(.WIDTH(8), .LIMIT(255)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.dma_req && !w_dma_gnt),
    .clr   (!bus.dma_req || w_dma_gnt),
    .load1 (1'b0),
    .cnt   (w_starve_cnt)
  );

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.cpu_hold   = bus.cpu_req && !w_cpu_gnt;
  assign bus.cpu_rvalid = w_cpu_rvalid;
  assign bus.dma_rvalid = w_dma_rvalid;
  assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : r_cpu_rdata;
  assign bus.dma_rdata  = w_dma_rvalid ? bus.mem_rdata : r_dma_rdata;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_we     = w_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4096x16 synchronous RAM.
module tb_mem_arbiter;
  import mem_arb_defs::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [15:0] ram [4096];

  mem_arbiter_if #(.AW(12), .DW(16)) bus ();

  mem_arbiter #(
    .AW           (12),
    .DW           (16),
    .MAX_BURST    (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [11:0] addr,
                         input logic [15:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [11:0] addr,
                         input logic [15:0] wdata, input logic lock);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
    bus.dma_lock  = lock;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int unsigned i = 0; i < 4096; i++) ram[i] = '0;
    bus.mem_rdata = '0;
    rst = 1'b0;
    set_cpu(1'b1, 1'b1, 12'h0A5, 16'h1234);
    set_dma(1'b1, 1'b1, 12'h100, 16'hBEEF, 1'b0);

    // Reset with both requesters active
    #2;
    chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    chk("rst_dma_gnt",    32'(bus.dma_gnt),    32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Release: CPU write 0x0A5 = 0x1234
    rst = 1'b1;
    set_dma(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("wr_cpu_gnt",   32'(bus.cpu_gnt),   32'd1);
    chk("wr_cpu_hold",  32'(bus.cpu_hold),  32'd0);
    chk("wr_dma_gnt",   32'(bus.dma_gnt),   32'd0);
    chk("wr_mem_we",    32'(bus.mem_we),    32'd1);
    chk("wr_mem_addr",  32'(bus.mem_addr),  32'h0A5);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h1234);

    // CPU read 0x0A5
    next_cycle();
    set_cpu(1'b1, 1'b0, 12'h0A5, 16'h0000);
    @(negedge clk);
    chk("rd_cpu_gnt",   32'(bus.cpu_gnt),   32'd1);
    chk("rd_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rd_mem_addr",  32'(bus.mem_addr),  32'h0A5);

    // Read data returns while DMA writes 0x200 = 0x5A5A
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    set_dma(1'b1, 1'b1, 12'h200, 16'h5A5A, 1'b0);
    @(negedge clk);
    chk("rv_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rv_cpu_rdata",  32'(bus.cpu_rdata),  32'h1234);
    chk("rv_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("dw_dma_gnt",    32'(bus.dma_gnt),    32'd1);
    chk("dw_mem_we",     32'(bus.mem_we),     32'd1);
    chk("dw_mem_addr",   32'(bus.mem_addr),   32'h200);

    // DMA write 0x100 = 0xBEEF; CPU rdata held
    next_cycle();
    set_dma(1'b1, 1'b1, 12'h100, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk("dw2_dma_gnt",    32'(bus.dma_gnt),    32'd1);
    chk("hold_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("hold_cpu_rdata",  32'(bus.cpu_rdata),  32'h1234);

    // Interleaved reads: CPU 0x0A5, DMA 0x100, CPU 0x200
    next_cycle();
    set_dma(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    set_cpu(1'b1, 1'b0, 12'h0A5, 16'h0000);
    @(negedge clk);
    chk("il1_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);

    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    set_dma(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0);
    @(negedge clk);
    chk("il2_dma_gnt",    32'(bus.dma_gnt),    32'd1);
    chk("il2_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("il2_cpu_rdata",  32'(bus.cpu_rdata),  32'h1234);
    chk("il2_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);

    next_cycle();
    set_dma(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    set_cpu(1'b1, 1'b0, 12'h200, 16'h0000);
    @(negedge clk);
    chk("il3_cpu_gnt",    32'(bus.cpu_gnt),    32'd1);
    chk("il3_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    chk("il3_dma_rdata",  32'(bus.dma_rdata),  32'hBEEF);
    chk("il3_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("il3_cpu_rdata",  32'(bus.cpu_rdata),  32'h1234);

    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    @(negedge clk);
    chk("il4_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("il4_cpu_rdata",  32'(bus.cpu_rdata),  32'h5A5A);
    chk("il4_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("il4_dma_rdata",  32'(bus.dma_rdata),  32'hBEEF);
    chk("il4_mem_addr",   32'(bus.mem_addr),   32'h200);
    chk("il4_mem_wdata",  32'(bus.mem_wdata),  32'h0);

    // Simultaneous requests, no lock: 4 CPU grants then forced DMA
    next_cycle();
    set_cpu(1'b1, 1'b0, 12'h0A5, 16'h0000);
    set_dma(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("sim_cpu_gnt_c%0d", c),  32'(bus.cpu_gnt),  (c < 5) ? 32'd1 : 32'd0);
      chk($sformatf("sim_dma_gnt_c%0d", c),  32'(bus.dma_gnt),  (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("sim_cpu_hold_c%0d", c), 32'(bus.cpu_hold), (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("sim_starve_c%0d", c),   32'(dut.w_starve_cnt), 32'(c - 1));
      next_cycle();
    end
    set_dma(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("sim6_cpu_gnt",    32'(bus.cpu_gnt),       32'd1);
    chk("sim6_dma_rvalid", 32'(bus.dma_rvalid),    32'd1);
    chk("sim6_dma_rdata",  32'(bus.dma_rdata),     32'hBEEF);
    chk("sim6_starve",     32'(dut.w_starve_cnt),  32'd0);

    // Locked burst: forced entry at cycle 5, 8 DMA grants, then CPU
    next_cycle();
    set_cpu(1'b1, 1'b0, 12'h0A5, 16'h0000);
    set_dma(1'b1, 1'b0, 12'h100, 16'h0000, 1'b1);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("bst_cpu_gnt_c%0d", c),  32'(bus.cpu_gnt),
          (c < 5 || c == 13) ? 32'd1 : 32'd0);
      chk($sformatf("bst_dma_gnt_c%0d", c),  32'(bus.dma_gnt),
          (c >= 5 && c <= 12) ? 32'd1 : 32'd0);
      chk($sformatf("bst_cpu_hold_c%0d", c), 32'(bus.cpu_hold),
          (c >= 5 && c <= 12) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Reset asserted while a DMA read is in flight
    set_cpu(1'b0, 1'b0, 12'h000, 16'h0000);
    set_dma(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0);
    @(negedge clk);
    chk("mr_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_dma_gnt_rst",    32'(bus.dma_gnt),    32'd0);
    chk("mr_dma_rvalid_rst", 32'(bus.dma_rvalid), 32'd0);
    set_dma(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("mr_dma_rdata",  32'(bus.dma_rdata),  32'd0);
    chk("mr_owner",      32'(dut.r_owner),    32'(IDLE));
    chk("mr_mem_addr",   32'(bus.mem_addr),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 4096x16 RAM between the CPU datapath (addressed by AR, driven by the control unit's memory strobes) and a DMA/program-loader requester. It sits between the requesters and the RAM: it selects one requester per cycle, steers address, write data and write enable to the RAM, and returns read data with a per-port valid. It also produces a stall for the CPU sequence timer while the CPU is waiting. The CPU has fixed priority. A DMA burst may hold the RAM for a bounded number of cycles, and a starvation counter guarantees DMA progress.

## Interface
- AW, 12, RAM address width
- DW, 16, RAM data width
- MAX_BURST, 8, max consecutive DMA grants under lock while the CPU is waiting (1..255)
- STARVE_LIMIT, 4, consecutive denied DMA request cycles before DMA is forced ahead of the CPU (1..255)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU requests access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_hold  out  1  cpu_req & ~cpu_gnt; gates the sequence-timer clock
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata: same as CPU equivalents, for the DMA port
- dma_lock  in  1  request to keep ownership across consecutive cycles (burst)
- dma_gnt, dma_rvalid, dma_rdata: same as CPU equivalents, for the DMA port
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DW  RAM read data, valid one cycle after the address is presented

## Operation
- State register `owner`: IDLE, CPU, DMA. `burst_cnt` is 8 bits, saturating. `starve_cnt` is 8 bits, saturating.
- Grant decision, combinational from the registered state and the current requests. At most one grant per cycle. Priority order:
  1. `force_dma` = dma_req & (starve_cnt >= STARVE_LIMIT) grants DMA.
  2. owner == DMA & dma_lock & dma_req & (burst_cnt < MAX_BURST | ~cpu_req) grants DMA.
  3. cpu_req grants CPU.
  4. dma_req grants DMA.
- Steering: mem_addr and mem_wdata come from the granted port. If neither port is granted, mem_addr holds its last registered value and mem_wdata is 0. mem_we = gnt & we of the granted port.
- owner next state: the granted port, or IDLE when no port is granted.
- burst_cnt:
  - increments on each DMA grant while owner == DMA.
  - loads 1 on a DMA grant from any other owner.
  - clears to 0 when DMA is not granted.
- starve_cnt:
  - increments when dma_req is high and dma_gnt is low.
  - clears to 0 on any DMA grant or when dma_req is low.
- Read return: a granted read registers `rd_port` (1 bit) and `rd_pend`. In the next cycle the matching `*_rvalid` is 1 and `*_rdata` = mem_rdata. The other port's rdata is held.
- Write-then-read to the same address in consecutive cycles returns the new data; this is RAM behaviour and the arbiter adds no bypass.
- Requesters must hold request, we, addr and wdata stable until they see gnt. A request dropped before grant is abandoned with no side effect.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when the request wins; the write commits at the end of that cycle.
- Read latency: 1 cycle, from gnt to rvalid. Back-to-back reads give rvalid every cycle.
- A DMA burst under lock with cpu_req high gets exactly MAX_BURST grants. The CPU then gets at least one grant before DMA can win again, unless starve_cnt reaches STARVE_LIMIT first.
- Worst-case DMA wait under continuous cpu_req: STARVE_LIMIT cycles.
- Reset (asynchronous assert, any time):
  - owner=IDLE, counters=0, rd_pend=0.
  - all gnt, rvalid and mem_we = 0; rdata, mem_addr and mem_wdata = 0.
  - A read in flight is dropped and no rvalid follows.
- Reset release takes effect at the first clock edge after deassertion.

## Structure
- Shared package/header `mem_arb_defs`: owner state encodings (IDLE=2'd0, CPU=2'd1, DMA=2'd2), port ID constants (PORT_CPU=0, PORT_DMA=1).
- One natural sub-module: `sat_counter` (width and limit parameters, inc/clr/load1 inputs), instantiated for burst_cnt and starve_cnt.
- Everything else is flat: the grant logic, steering mux and read-return pipe.

## Test plan
- Reset check: apply rst=0 with both req=1 → all gnt, rvalid and mem_we are 0, mem_addr=0. After release, the first edge grants CPU.
- CPU write then read: cpu write 0x0A5 = 16'h1234, then read 0x0A5 → cpu_gnt both cycles, mem_we=1 in the first cycle only, cpu_rvalid=1 with cpu_rdata=16'h1234 one cycle after the read grant.
- Simultaneous requests: cpu_req and dma_req both raised, no lock, STARVE_LIMIT=4 → CPU granted for 4 cycles, DMA granted in cycle 5, starve_cnt then returns to 0.
- DMA locked burst: dma_lock=1 with DMA owning and cpu_req=1, MAX_BURST=8 → exactly 8 consecutive dma_gnt, then cpu_gnt. cpu_hold=1 for those 8 cycles.
- Reset mid-read: DMA read granted, then rst asserted before the next edge → dma_rvalid stays 0 and the post-reset state is IDLE.
- Interleaved reads: CPU and DMA reads alternate → each rvalid appears only on the issuing port, with the correct data, 1 cycle after that port's grant.
